// File: rtl/bank_htu_req_queue.sv
// bank_htu_req_queue: per-bank FIFO from cross bar to HTU with same-line in-flight hazard blocking
module bank_htu_req_queue #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             xbar_req_valid_i,
   output logic             xbar_req_allowIn_o,
   input  logic [1:0]       xbar_req_ch_id_i,
   input  logic [1:0]       xbar_req_opcode_i,
   input  logic [27:0]      xbar_req_addr_i,
   input  logic [7:0]       xbar_req_wbuffer_id_i,
   output logic             htu_req_valid_o,
   input  logic             htu_req_ready_i,
   output logic [1:0]       htu_req_ch_id_o,
   output logic [1:0]       htu_req_opcode_o,
   output logic [27:0]      htu_req_addr_o,
   output logic [7:0]       htu_req_wbuffer_id_o,
   input  logic             htu_resp_valid_i,
   output logic [PTR_W:0]   queue_count_o
);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
   logic [39:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             inflight_valid_q, inflight_valid_d;
   logic [27:0]      inflight_addr_q, inflight_addr_d;
   logic [39:0]      head;
   logic             enq, iss, hazard, empty;

   assign {htu_req_ch_id_o, htu_req_opcode_o, htu_req_addr_o, htu_req_wbuffer_id_o} = head;
   assign queue_count_o = count_q;

   // handshakes, hazard check and next state for pointers, occupancy and in-flight tracker
   always_comb begin
      head = mem_q[rd_ptr_q];
      empty = count_q == '0;
      hazard = inflight_valid_q & (head[35:8] == inflight_addr_q);
      xbar_req_allowIn_o = count_q != CNT_FULL;
      htu_req_valid_o = ~empty & ~hazard;
      enq = xbar_req_valid_i & xbar_req_allowIn_o;
      iss = htu_req_valid_o & htu_req_ready_i;
      wr_ptr_d = wr_ptr_q + PTR_W'(enq);
      rd_ptr_d = rd_ptr_q + PTR_W'(iss);
      count_d = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(iss);
      inflight_valid_d = iss ? 1'b1 : htu_resp_valid_i ? 1'b0 : inflight_valid_q;
      inflight_addr_d = iss ? head[35:8] : inflight_addr_q;
   end

   // entry storage; contents survive reset, only pointers are cleared
   always_ff @(posedge clk_i) begin
      if (enq) mem_q[wr_ptr_q] <= {xbar_req_ch_id_i, xbar_req_opcode_i, xbar_req_addr_i, xbar_req_wbuffer_id_i};
   end

   // control state with asynchronous flush
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
         inflight_valid_q <= 1'b0;
         inflight_addr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
         inflight_valid_q <= inflight_valid_d;
         inflight_addr_q <= inflight_addr_d;
      end
   end
endmodule

// File: tb/tb_bank_htu_req_queue.sv
// tb_bank_htu_req_queue: directed bench with a queue-based reference model of the request queue
module tb_bank_htu_req_queue;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        xbar_req_valid_i = 1'b0;
   logic        xbar_req_allowIn_o;
   logic [1:0]  xbar_req_ch_id_i = '0;
   logic [1:0]  xbar_req_opcode_i = '0;
   logic [27:0] xbar_req_addr_i = '0;
   logic [7:0]  xbar_req_wbuffer_id_i = '0;
   logic        htu_req_valid_o;
   logic        htu_req_ready_i = 1'b0;
   logic [1:0]  htu_req_ch_id_o;
   logic [1:0]  htu_req_opcode_o;
   logic [27:0] htu_req_addr_o;
   logic [7:0]  htu_req_wbuffer_id_o;
   logic        htu_resp_valid_i = 1'b0;
   logic [2:0]  queue_count_o;

   int n_chk = 0;
   int n_fail = 0;

   bank_htu_req_queue #(.DEPTH(4), .PTR_W(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .xbar_req_valid_i(xbar_req_valid_i), .xbar_req_allowIn_o(xbar_req_allowIn_o),
      .xbar_req_ch_id_i(xbar_req_ch_id_i), .xbar_req_opcode_i(xbar_req_opcode_i),
      .xbar_req_addr_i(xbar_req_addr_i), .xbar_req_wbuffer_id_i(xbar_req_wbuffer_id_i),
      .htu_req_valid_o(htu_req_valid_o), .htu_req_ready_i(htu_req_ready_i),
      .htu_req_ch_id_o(htu_req_ch_id_o), .htu_req_opcode_o(htu_req_opcode_o),
      .htu_req_addr_o(htu_req_addr_o), .htu_req_wbuffer_id_o(htu_req_wbuffer_id_o),
      .htu_resp_valid_i(htu_resp_valid_i), .queue_count_o(queue_count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: a plain queue of {ch, op, addr, wbid} plus the in-flight line
   logic [39:0] mq[$];
   logic        mfv;
   logic [27:0] maddr;
   logic [39:0] mh;
   bit          m_enq, m_iss;

   function automatic bit m_valid();
      return mq.size() > 0 && !(mfv && mq[0][35:8] == maddr);
   endfunction

   always @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mq.delete();
         mfv = 1'b0;
         maddr = '0;
      end else begin
         m_enq = xbar_req_valid_i && mq.size() < 4;
         m_iss = m_valid() && htu_req_ready_i;
         if (m_iss) begin
            mh = mq.pop_front();
            mfv = 1'b1;
            maddr = mh[35:8];
         end else if (htu_resp_valid_i) mfv = 1'b0;
         if (m_enq) mq.push_back({xbar_req_ch_id_i, xbar_req_opcode_i, xbar_req_addr_i, xbar_req_wbuffer_id_i});
      end
   end

   always @(negedge clk_i) begin
      if (rst_i) begin
         chk("allowIn", 64'(xbar_req_allowIn_o), 64'(mq.size() < 4));
         chk("valid", 64'(htu_req_valid_o), 64'(m_valid()));
         chk("count", 64'(queue_count_o), 64'(mq.size()));
         if (mq.size() > 0)
            chk("head", 64'({htu_req_ch_id_o, htu_req_opcode_o, htu_req_addr_o, htu_req_wbuffer_id_o}), 64'(mq[0]));
      end
   end

   task automatic step(input bit v, input logic [1:0] ch, input logic [1:0] op, input logic [27:0] a,
                       input logic [7:0] wb, input bit rdy, input bit rsp);
      xbar_req_valid_i = v;
      xbar_req_ch_id_i = ch;
      xbar_req_opcode_i = op;
      xbar_req_addr_i = a;
      xbar_req_wbuffer_id_i = wb;
      htu_req_ready_i = rdy;
      htu_resp_valid_i = rsp;
      @(posedge clk_i);
      #1;
   endtask

   task automatic en(input logic [27:0] a, input bit rdy, input bit rsp);
      step(1'b1, 2'd2, 2'd1, a, a[7:0], rdy, rsp);
   endtask

   task automatic idle(input bit rdy, input bit rsp);
      step(1'b0, 2'd0, 2'd0, 28'h0, 8'h0, rdy, rsp);
   endtask

   initial begin
      #3 rst_i = 1'b0;
      #1;
      chk("rst_count", 64'(queue_count_o), 64'd0);
      chk("rst_allow", 64'(xbar_req_allowIn_o), 64'd1);
      chk("rst_valid", 64'(htu_req_valid_o), 64'd0);
      @(posedge clk_i);
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      // single request flows through
      step(1'b1, 2'd1, 2'd2, 28'h0000010, 8'h05, 1'b1, 1'b0);
      chk("t1_valid", 64'(htu_req_valid_o), 64'd1);
      chk("t1_ch", 64'(htu_req_ch_id_o), 64'd1);
      chk("t1_op", 64'(htu_req_opcode_o), 64'd2);
      chk("t1_addr", 64'(htu_req_addr_o), 64'h10);
      chk("t1_wbid", 64'(htu_req_wbuffer_id_o), 64'h05);
      chk("t1_count", 64'(queue_count_o), 64'd1);
      idle(1'b1, 1'b0);
      chk("t1_drained", 64'(queue_count_o), 64'd0);
      chk("t1_novalid", 64'(htu_req_valid_o), 64'd0);
      idle(1'b0, 1'b1);
      // fill to full, reject a fifth, then drain in order
      for (int i = 0; i < 4; i++) en(28'h100 + 28'(i), 1'b0, 1'b0);
      chk("full_allow", 64'(xbar_req_allowIn_o), 64'd0);
      chk("full_count", 64'(queue_count_o), 64'd4);
      en(28'h104, 1'b0, 1'b0);
      chk("fifth_rejected", 64'(queue_count_o), 64'd4);
      chk("full_head", 64'(htu_req_addr_o), 64'h100);
      idle(1'b1, 1'b0);
      chk("after_issue_count", 64'(queue_count_o), 64'd3);
      chk("after_issue_allow", 64'(xbar_req_allowIn_o), 64'd1);
      chk("order_head", 64'(htu_req_addr_o), 64'h101);
      for (int i = 0; i < 3; i++) idle(1'b1, 1'b1);
      chk("drain_count", 64'(queue_count_o), 64'd0);
      idle(1'b0, 1'b1);
      // same-line hazard blocks until the response
      en(28'h0000A00, 1'b1, 1'b0);
      idle(1'b1, 1'b0);
      en(28'h0000A00, 1'b1, 1'b0);
      chk("haz_block", 64'(htu_req_valid_o), 64'd0);
      idle(1'b1, 1'b0);
      chk("haz_hold", 64'(htu_req_valid_o), 64'd0);
      chk("haz_count", 64'(queue_count_o), 64'd1);
      idle(1'b1, 1'b1);
      chk("haz_clear", 64'(htu_req_valid_o), 64'd1);
      idle(1'b1, 1'b0);
      // a different line issues while A00 is in flight, then B00 becomes the tracked line
      en(28'h0000B00, 1'b1, 1'b0);
      chk("diff_line", 64'(htu_req_valid_o), 64'd1);
      idle(1'b1, 1'b0);
      chk("diff_issued", 64'(queue_count_o), 64'd0);
      en(28'h0000B00, 1'b1, 1'b0);
      chk("inflight_b00", 64'(htu_req_valid_o), 64'd0);
      idle(1'b0, 1'b1);
      chk("b00_clear", 64'(htu_req_valid_o), 64'd1);
      idle(1'b1, 1'b0);
      // issue and response together: set wins with the new line
      en(28'h0000C00, 1'b0, 1'b0);
      en(28'h0000C00, 1'b1, 1'b1);
      chk("set_wins", 64'(htu_req_valid_o), 64'd0);
      chk("set_wins_count", 64'(queue_count_o), 64'd1);
      idle(1'b0, 1'b0);
      chk("set_wins_hold", 64'(htu_req_valid_o), 64'd0);
      idle(1'b0, 1'b1);
      chk("set_wins_clear", 64'(htu_req_valid_o), 64'd1);
      idle(1'b1, 1'b0);
      // asynchronous flush with entries queued and one in flight
      en(28'h0000D00, 1'b0, 1'b0);
      en(28'h0000D01, 1'b0, 1'b0);
      en(28'h0000D02, 1'b0, 1'b0);
      chk("pre_rst_count", 64'(queue_count_o), 64'd3);
      idle(1'b0, 1'b0);
      #1 rst_i = 1'b0;
      #1;
      chk("arst_count", 64'(queue_count_o), 64'd0);
      chk("arst_valid", 64'(htu_req_valid_o), 64'd0);
      chk("arst_allow", 64'(xbar_req_allowIn_o), 64'd1);
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      en(28'h0000C00, 1'b1, 1'b0);
      chk("post_rst_valid", 64'(htu_req_valid_o), 64'd1);
      chk("post_rst_addr", 64'(htu_req_addr_o), 64'hC00);
      idle(1'b1, 1'b0);
      chk("post_rst_drained", 64'(queue_count_o), 64'd0);
      idle(1'b0, 1'b1);
      idle(1'b0, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/bank_htu_req_queue.md
# bank_htu_req_queue

Per-bank request queue between the cross bar and one bank's hit-test unit (HTU). It accepts the arbitrated request the cross bar drives for that bank and buffers it in a DEPTH-entry FIFO. It presents the oldest entry to the HTU with a valid/ready handshake. It also blocks a same-line request from issuing while an earlier request to that line is still in flight in the HTU. One instance per bank (bank0..bank3).

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- PTR_W, 2: log2(DEPTH).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- xbar_req_valid_i  in  1  cross bar has a request for this bank.
- xbar_req_allowIn_o  out  1  queue can accept; handshake = valid_i & allowIn_o.
- xbar_req_ch_id_i  in  2  source channel (0..2).
- xbar_req_opcode_i  in  2  request opcode.
- xbar_req_addr_i  in  28 [31:4]  line address.
- xbar_req_wbuffer_id_i  in  8  write-buffer id.
- htu_req_valid_o  out  1  head entry issuable.
- htu_req_ready_i  in  1  HTU accepts; issue = valid_o & ready_i.
- htu_req_ch_id_o / opcode_o / addr_o / wbuffer_id_o  out  2/2/28/8  head entry fields.
- htu_resp_valid_i  in  1  HTU has retired the in-flight request; single-cycle pulse.
- queue_count_o  out  PTR_W+1  current occupancy.

## Operation
- Storage: DEPTH x 40-bit entries {ch_id, opcode, addr, wbuffer_id}, written at wr_ptr, read at rd_ptr. Pointers are PTR_W bits and wrap modulo DEPTH. count is PTR_W+1 bits.
- Enqueue: on xbar handshake, write the entry at wr_ptr and advance wr_ptr.
- Dequeue: on HTU issue, advance rd_ptr.
- Count update:
  - count += 1 on enqueue only.
  - count -= 1 on issue only.
  - count unchanged when both occur in the same cycle.
- Full/empty:
  - full = (count == DEPTH).
  - empty = (count == 0).
  - xbar_req_allowIn_o = ~full. It is combinational from count only and never depends on xbar_req_valid_i.
- Output fields: driven directly from entry[rd_ptr] (first-word-fall-through). When empty they hold the stale entry contents; the bench must not check them then.
- In-flight tracker: one register pair, inflight_valid and inflight_addr[31:4].
  - On issue: inflight_valid <= 1 and inflight_addr <= head addr.
  - On htu_resp_valid_i with no issue in the same cycle: inflight_valid <= 0.
  - Issue and resp in the same cycle: the set wins, and inflight_addr takes the newly issued address.
- Hazard: hazard = inflight_valid & (head addr == inflight_addr). The comparison covers the full 28 bits and ignores opcode.
- htu_req_valid_o = ~empty & ~hazard.
  - A request to a different line issues even while another request is in flight.
  - A blocked head blocks all younger entries (strict in-order issue).
- htu_resp_valid_i while inflight_valid = 0 is ignored.

## Timing
- Reset (rst_i low, asynchronous):
  - wr_ptr, rd_ptr, count = 0.
  - inflight_valid = 0; inflight_addr = 0.
  - Resulting outputs: xbar_req_allowIn_o = 1, htu_req_valid_o = 0, queue_count_o = 0.
  - Storage contents are not reset.
- Reset mid-operation flushes all entries and clears the in-flight state immediately. Release is synchronous to the next clk_i edge.
- Latency: an entry enqueued in cycle N is visible at the head in cycle N+1 at the earliest. There is no same-cycle bypass.
- Hazard clear: htu_resp_valid_i in cycle N makes a hazard-blocked head valid in cycle N+1.
- Full: when count reaches DEPTH, allowIn_o drops in the same cycle. An issue in cycle N raises allowIn_o in cycle N+1, not N.
- Throughput: one enqueue and one issue per cycle sustained when no hazard exists.
- htu_req_valid_o may deassert without a handshake only when the hazard sets in the same cycle as an issue. For non-hazard stalls, the head holds stable until issued.

## Test plan
- Reset, then enqueue 1 request (ch 1, op 2, addr 0x0000010, wbid 0x05) with ready = 1 → htu_req_valid_o = 1 the next cycle with the same fields; issued; count returns to 0.
- ready = 0 with 4 enqueues → allowIn_o = 0 after the 4th, queue_count_o = 4, a 5th valid is not accepted. Then ready = 1 → entries issue in order, allowIn_o returns 1 cycle after the first issue.
- Issue addr 0x0000A00, then enqueue the same addr → head held with valid_o = 0. Pulse htu_resp_valid_i → valid_o = 1 the next cycle.
- In-flight addr 0x0000A00, head addr 0x0000B00 → issues immediately; inflight_addr becomes 0x0000B00.
- Issue and resp in the same cycle → inflight_valid stays 1 with the new addr; a following same-addr entry stays blocked.
- Assert rst_i low with 3 entries queued and one in flight → count = 0, valid_o = 0, allowIn_o = 1 asynchronously; after release, a new request passes normally.
